// File: rtl/button_event_classifier.sv
// Classifies debounced key_down/key_up pulses into short-press, long-press and
// double-click events. Optional auto-repeat while held: BUTTON_EVENT_AUTO_REPEAT_EN.
module button_event_classifier #(
    parameter int CNT_WIDTH     = 24,
    parameter int LONG_CYCLES   = 10_000_000,
    parameter int DCLICK_CYCLES = 5_000_000,
    parameter int REPEAT_CYCLES = 2_500_000,
    parameter int EVT_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_down_i,
    input  logic                     key_up_i,
    output logic                     short_press_o,
    output logic                     long_press_o,
    output logic                     double_click_o,
    output logic                     repeat_o,
    output logic                     busy_o,
    output logic [EVT_CNT_WIDTH-1:0] event_cnt_o
);

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DCLICK_LAST = CNT_WIDTH'(DCLICK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                     short_q, short_d;
    logic                     long_q, long_d;
    logic                     dclick_q, dclick_d;
    logic                     repeat_q, repeat_d;
    logic                     busy_q, busy_d;
    logic [EVT_CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic [2:0]               evt_inc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        dclick_d = 1'b0;
        repeat_d = 1'b0;
        cnt_inc  = cnt_q + CNT_WIDTH'(1);

        // Release is checked before the timeout so it wins a same-cycle tie.
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key_down_i) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (key_up_i) begin
                    state_d = WAIT_SECOND;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LONG_HELD: begin
                if (key_up_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!REPEAT_EN) begin
                    cnt_d = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_SECOND: begin
                if (key_down_i) begin
                    state_d = SECOND_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DCLICK_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SECOND_PRESSED: begin
                if (key_up_i) begin
                    dclick_d = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == LONG_LAST) begin
                    // The first click stands alone; the held second press is a long press.
                    short_d = 1'b1;
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d    = (state_d != IDLE);
        evt_inc   = 3'(short_d) + 3'(long_d) + 3'(dclick_d) + 3'(repeat_d);
        evt_cnt_d = evt_cnt_q + EVT_CNT_WIDTH'(evt_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dclick_q  <= 1'b0;
            repeat_q  <= 1'b0;
            busy_q    <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            short_q   <= short_d;
            long_q    <= long_d;
            dclick_q  <= dclick_d;
            repeat_q  <= repeat_d;
            busy_q    <= busy_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign short_press_o  = short_q;
    assign long_press_o   = long_q;
    assign double_click_o = dclick_q;
    assign repeat_o       = repeat_q;
    assign busy_o         = busy_q;
    assign event_cnt_o    = evt_cnt_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with shortened timing parameters.
module tb_button_event_classifier;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_down_i;
    logic       key_up_i;
    logic       short_press_o;
    logic       long_press_o;
    logic       double_click_o;
    logic       repeat_o;
    logic       busy_o;
    logic [7:0] event_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor, relative to the last clear_mon() call.
    int cyc;
    int n_short, n_long, n_dclick, n_rep;
    int at_short, at_long, at_dclick;
    int rep_q[$];

    button_event_classifier #(
        .CNT_WIDTH    (24),
        .LONG_CYCLES  (20),
        .DCLICK_CYCLES(10),
        .REPEAT_CYCLES(5),
        .EVT_CNT_WIDTH(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_down_i    (key_down_i),
        .key_up_i      (key_up_i),
        .short_press_o (short_press_o),
        .long_press_o  (long_press_o),
        .double_click_o(double_click_o),
        .repeat_o      (repeat_o),
        .busy_o        (busy_o),
        .event_cnt_o   (event_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic clear_mon();
        cyc = 0; n_short = 0; n_long = 0; n_dclick = 0; n_rep = 0;
        at_short = -1; at_long = -1; at_dclick = -1;
        rep_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (short_press_o)  begin n_short++;  at_short  = cyc; end
        if (long_press_o)   begin n_long++;   at_long   = cyc; end
        if (double_click_o) begin n_dclick++; at_dclick = cyc; end
        if (repeat_o)       begin n_rep++;    rep_q.push_back(cyc); end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic press();
        key_down_i = 1'b1;
        step();
        key_down_i = 1'b0;
    endtask

    task automatic release_key();
        key_up_i = 1'b1;
        step();
        key_up_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #4;
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset();
        // Reset has been held since time 0.
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if ({short_press_o, long_press_o, double_click_o, repeat_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=0000", {short_press_o, long_press_o, double_click_o, repeat_o}); end
        checks++; if (event_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_evt_cnt got=%0d exp=0", event_cnt_o); end
        reset = 1'b0;
        clear_mon();
        press(); release_key(); idle(10);
        checks++; if (event_cnt_o !== 8'd1) begin failures++; $display("FAIL reset_pre_evt got=%0d exp=1", event_cnt_o); end
        press(); idle(3);
        #3 reset = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_async_busy got=%0b exp=0", busy_o); end
        checks++; if (event_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_async_evt got=%0d exp=0", event_cnt_o); end
        #3 reset = 1'b0;
        clear_mon();
        release_key(); idle(15);
        checks++; if (n_short + n_long + n_dclick + n_rep !== 0) begin
            failures++; $display("FAIL reset_orphan_up got=%0d events exp=0", n_short + n_long + n_dclick + n_rep); end
        checks++; if (event_cnt_o !== 8'd0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL reset_orphan_state got=evt%0d/busy%0b exp=evt0/busy0", event_cnt_o, busy_o); end
        $display("test_reset done");
    endtask

    task automatic test_short_press();
        do_reset();
        press();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL short_busy_after_down got=%0b exp=1", busy_o); end
        idle(4);
        release_key();
        clear_mon();
        idle(15);
        checks++; if (n_short !== 1 || at_short !== 10) begin
            failures++; $display("FAIL short_timing got=n%0d@%0d exp=n1@10", n_short, at_short); end
        checks++; if (n_long + n_dclick !== 0) begin failures++; $display("FAIL short_other got=%0d exp=0", n_long + n_dclick); end
        checks++; if (event_cnt_o !== 8'd1) begin failures++; $display("FAIL short_evt_cnt got=%0d exp=1", event_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL short_busy_end got=%0b exp=0", busy_o); end
        $display("test_short_press done");
    endtask

    task automatic test_long_press();
        int exp_rep;
        logic [7:0] exp_cnt;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        exp_rep = 3; exp_cnt = 8'd4;
`else
        exp_rep = 0; exp_cnt = 8'd1;
`endif
        do_reset();
        press();
        clear_mon();
        idle(39);
        release_key();  // lands on the terminal repeat cycle
        checks++; if (n_long !== 1 || at_long !== 20) begin
            failures++; $display("FAIL long_timing got=n%0d@%0d exp=n1@20", n_long, at_long); end
        checks++; if (n_short !== 0) begin failures++; $display("FAIL long_no_short got=%0d exp=0", n_short); end
        checks++; if (n_rep !== exp_rep) begin failures++; $display("FAIL long_repeat_count got=%0d exp=%0d", n_rep, exp_rep); end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        if (rep_q.size() == 3) begin
            checks++; if (rep_q[0] !== 25 || rep_q[1] !== 30 || rep_q[2] !== 35) begin
                failures++; $display("FAIL long_repeat_times got=%0d,%0d,%0d exp=25,30,35", rep_q[0], rep_q[1], rep_q[2]); end
        end
`endif
        checks++; if (event_cnt_o !== exp_cnt) begin failures++; $display("FAIL long_evt_cnt got=%0d exp=%0d", event_cnt_o, exp_cnt); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL long_busy_end got=%0b exp=0", busy_o); end
        $display("test_long_press done");
    endtask

    task automatic test_double_click();
        do_reset();
        press(); idle(2); release_key();
        idle(3); press(); idle(2); release_key();
        checks++; if (double_click_o !== 1'b1 || at_dclick !== 11) begin
            failures++; $display("FAIL dclick_timing got=%0b@%0d exp=1@11", double_click_o, at_dclick); end
        idle(15);
        checks++; if (n_dclick !== 1 || n_short !== 0 || n_long !== 0) begin
            failures++; $display("FAIL dclick_events got=d%0d/s%0d/l%0d exp=d1/s0/l0", n_dclick, n_short, n_long); end
        checks++; if (event_cnt_o !== 8'd1) begin failures++; $display("FAIL dclick_evt_cnt got=%0d exp=1", event_cnt_o); end
        $display("test_double_click done");
    endtask

    task automatic test_tie_release();
        do_reset();
        press();
        clear_mon();
        idle(19);
        release_key();  // counter is at LONG_CYCLES-1 on this edge
        idle(10);
        checks++; if (n_long !== 0) begin failures++; $display("FAIL tie_release_long got=%0d exp=0", n_long); end
        checks++; if (n_short !== 1 || at_short !== 30) begin
            failures++; $display("FAIL tie_release_short got=n%0d@%0d exp=n1@30", n_short, at_short); end
        $display("test_tie_release done");
    endtask

    task automatic test_tie_window();
        do_reset();
        press(); idle(2); release_key();
        clear_mon();
        idle(9);
        press();  // window counter is at DCLICK_CYCLES-1 on this edge
        checks++; if (n_short !== 0 || busy_o !== 1'b1) begin
            failures++; $display("FAIL tie_window_state got=s%0d/busy%0b exp=s0/busy1", n_short, busy_o); end
        idle(2); release_key();
        checks++; if (double_click_o !== 1'b1) begin failures++; $display("FAIL tie_window_dclick got=%0b exp=1", double_click_o); end
        $display("test_tie_window done");
    endtask

    task automatic test_second_long();
        do_reset();
        press(); idle(2); release_key(); idle(3); press();
        clear_mon();
        idle(24);
        release_key();
        checks++; if (n_short !== 1 || n_long !== 1 || at_short !== 20 || at_long !== 20) begin
            failures++; $display("FAIL second_long_timing got=s%0d@%0d/l%0d@%0d exp=s1@20/l1@20", n_short, at_short, n_long, at_long); end
        checks++; if (event_cnt_o !== 8'd2) begin failures++; $display("FAIL second_long_evt_cnt got=%0d exp=2", event_cnt_o); end
        checks++; if (n_dclick !== 0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL second_long_end got=d%0d/busy%0b exp=d0/busy0", n_dclick, busy_o); end
        $display("test_second_long done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        key_down_i = 1'b1; key_up_i = 1'b1;
        step();  // IDLE: press wins
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL simul_idle_busy got=%0b exp=1", busy_o); end
        step();  // PRESSED: release wins
        key_down_i = 1'b0; key_up_i = 1'b0;
        clear_mon();
        idle(12);
        checks++; if (n_short !== 1 || at_short !== 10) begin
            failures++; $display("FAIL simul_short got=n%0d@%0d exp=n1@10", n_short, at_short); end
        $display("test_simultaneous done");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            press(); release_key(); idle(10);
            if (i == 254) begin
                checks++; if (event_cnt_o !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", event_cnt_o); end
            end
        end
        checks++; if (event_cnt_o !== 8'd0 || n_short !== 256) begin
            failures++; $display("FAIL wrap_zero got=evt%0d/s%0d exp=evt0/s256", event_cnt_o, n_short); end
        $display("test_wrap done");
    endtask

    initial begin
        reset = 1'b1;
        key_down_i = 1'b0;
        key_up_i = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_short_press();
        test_long_press();
        test_double_click();
        test_tie_release();
        test_tie_window();
        test_second_long();
        test_simultaneous();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
